// File: rtl/nibble_sub_sched.sv
// Two-requester, round-robin scheduled subtractor built around one shared 4-bit
// subtract slice that walks the operands a nibble per cycle, LSB nibble first.

module nibble_sub_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       bin,
  output logic [3:0] d,
  output logic       bout
);
  logic [4:0] c;

  assign c[0] = bin;
  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign d[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (~a[i] & b[i]) | ((~a[i] | b[i]) & c[i]);
  end
  assign bout = c[4];
endmodule

module nibble_sub_sched #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] A0,
  input  logic [WIDTH-1:0] B0,
  input  logic             Bin0,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] B1,
  input  logic             Bin1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH-1:0] Diff,
  output logic             Borrow_out
);
  localparam int NIBS = WIDTH / 4;
  localparam int CW   = (NIBS > 1) ? $clog2(NIBS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             id;
  } op_t;

  state_t           state, state_nxt;
  op_t              op_q, op_win;
  logic [CW-1:0]    cnt;
  logic             brw;
  logic             rr_last;
  logic [WIDTH-1:0] res_q, res_nxt;
  logic             capture, last, win_id;
  logic [3:0]       na, nb, nd;
  logic             nbin, nbout;

  // Tie goes to whoever was not granted last; rr_last resets to 1 so requester 0 wins first.
  always_comb begin
    win_id = (req0 && req1) ? ~rr_last : req1;
    op_win = win_id ? '{a: A1, b: B1, bin: Bin1, id: 1'b1}
                    : '{a: A0, b: B0, bin: Bin0, id: 1'b0};
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: if (req0 || req1) begin
        capture   = 1'b1;
        state_nxt = RUN;
      end
      RUN: if (cnt == LAST) begin
        last      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    na      = op_q.a[{cnt, 2'b00} +: 4];
    nb      = op_q.b[{cnt, 2'b00} +: 4];
    nbin    = (cnt == '0) ? op_q.bin : brw;
    res_nxt = res_q;
    res_nxt[{cnt, 2'b00} +: 4] = nd;
  end

  nibble_sub_slice u_slice (
    .a    (na),
    .b    (nb),
    .bin  (nbin),
    .d    (nd),
    .bout (nbout)
  );

  assign busy = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_q       <= '0;
      cnt        <= '0;
      brw        <= 1'b0;
      rr_last    <= 1'b1;
      res_q      <= '0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      done       <= 1'b0;
      done_id    <= 1'b0;
      Diff       <= '0;
      Borrow_out <= 1'b0;
    end else begin
      state <= state_nxt;
      gnt0  <= capture & ~win_id;
      gnt1  <= capture & win_id;
      done  <= last;
      if (capture) begin
        op_q    <= op_win;
        cnt     <= '0;
        rr_last <= win_id;
      end else if (state == RUN) begin
        cnt   <= last ? '0 : cnt + CW'(1);
        brw   <= nbout;
        res_q <= res_nxt;
      end
      if (last) begin
        Diff       <= res_nxt;
        Borrow_out <= nbout;
        done_id    <= op_q.id;
      end
    end
  end
endmodule

// File: tb/tb_nibble_sub_sched.sv
// Scoreboard bench: stimulus pushes expected results, a negedge monitor pops on done.

module tb_nibble_sub_sched;
  logic        clk, rst_n;
  logic        req0, req1;
  logic [15:0] A0, B0, A1, B1;
  logic        Bin0, Bin1;
  logic        gnt0, gnt1, busy, done, done_id;
  logic [15:0] Diff;
  logic        Borrow_out;

  nibble_sub_sched #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
    .A0(A0), .B0(B0), .Bin0(Bin0), .A1(A1), .B1(B1), .Bin1(Bin1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done), .done_id(done_id),
    .Diff(Diff), .Borrow_out(Borrow_out)
  );

  typedef struct {
    logic        id;
    logic [15:0] diff;
    logic        bout;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_done: got done with diff %0h, expected no done", Diff);
      end else begin
        mon_e = sb.pop_front();
        chk("done_id", done_id, mon_e.id);
        chk("diff", Diff, mon_e.diff);
        chk("borrow_out", Borrow_out, mon_e.bout);
      end
    end
  end

  function automatic exp_t model(input logic id, input logic [15:0] a, b, input logic bin);
    logic [16:0] t;
    exp_t e;
    t = {1'b0, a} - {1'b0, b} - 17'(bin);
    e.id = id;
    e.diff = t[15:0];
    e.bout = t[16];
    return e;
  endfunction

  task automatic wait_gnt(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (gnt0 || gnt1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    chk("queue_drained", sb.size(), 0);
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_gnt0"}, gnt0, 0);
    chk({tag, "_gnt1"}, gnt1, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_done_id"}, done_id, 0);
    chk({tag, "_diff"}, Diff, 0);
    chk({tag, "_borrow"}, Borrow_out, 0);
  endtask

  // Called at a negedge; returns at the negedge where the grant is visible.
  task automatic do_op(input logic id, input logic [15:0] a, b, input logic bin,
                       input logic [15:0] ed, input logic eb, input bit push);
    bit ok;
    if (id) begin A1 = a; B1 = b; Bin1 = bin; req1 = 1'b1; end
    else    begin A0 = a; B0 = b; Bin0 = bin; req0 = 1'b1; end
    if (push) sb.push_back('{id: id, diff: ed, bout: eb});
    wait_gnt(ok);
    chk("gnt_seen", ok, 1);
    if (ok) chk("gnt_id", {gnt1, gnt0}, id ? 2 : 1);
    if (id) req1 = 1'b0; else req0 = 1'b0;
  endtask

  initial begin
    bit ok;
    int n;
    logic id;
    logic [15:0] ra, rb;
    logic rbin;
    exp_t e;

    rst_n = 1'b0;
    req0 = 1'b1; A0 = 16'h1111; B0 = 16'h0001; Bin0 = 1'b0;
    req1 = 1'b1; A1 = 16'h0005; B1 = 16'h0007; Bin1 = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outs("reset");

    // Both requesters held from reset: grants must alternate 0,1,0,1.
    sb.push_back('{id: 1'b0, diff: 16'h1110, bout: 1'b0});
    sb.push_back('{id: 1'b1, diff: 16'hFFFE, bout: 1'b1});
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(ok);
      chk("tie_gnt_seen", ok, 1);
      chk("tie_gnt_id", {gnt1, gnt0}, (k % 2) ? 2 : 1);
      case (k)
        0: begin
          A0 = 16'hDEAD; B0 = 16'hBEEF; Bin0 = 1'b1;
          @(negedge clk);
          A0 = 16'h8000; B0 = 16'h7FFF; Bin0 = 1'b1;
          sb.push_back('{id: 1'b0, diff: 16'h0000, bout: 1'b0});
        end
        1: begin
          A1 = 16'hCAFE; B1 = 16'hF00D; Bin1 = 1'b1;
          @(negedge clk);
          A1 = 16'h3000; B1 = 16'h0FFF; Bin1 = 1'b0;
          sb.push_back('{id: 1'b1, diff: 16'h2001, bout: 1'b0});
        end
        2: begin req0 = 1'b0; A0 = 16'hFFFF; B0 = 16'h0000; end
        default: req1 = 1'b0;
      endcase
    end

    do_op(1'b0, 16'hAAAA, 16'h5555, 1'b0, 16'h5555, 1'b0, 1'b1);
    chk("busy_in_run", busy, 1);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n++;
      if (done) break;
    end
    chk("done_latency", n, 4);
    chk("busy_at_done", busy, 0);

    do_op(1'b1, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b1);
    do_op(1'b0, 16'h1234, 16'h1234, 1'b1, 16'hFFFF, 1'b1, 1'b1);
    do_op(1'b0, 16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b1);
    wait_empty();
    repeat (3) @(negedge clk);
    chk("hold_diff", Diff, 16'h0FFF);
    chk("hold_borrow", Borrow_out, 0);
    chk("hold_done_id", done_id, 0);

    // Abort at cnt=2: no done may follow for this operation.
    do_op(1'b0, 16'h4321, 16'h1111, 1'b0, 16'h0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outs("abort");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("abort_no_done_queue", sb.size(), 0);
    do_op(1'b1, 16'h0010, 16'h0001, 1'b1, 16'h000E, 1'b0, 1'b1);

    for (int i = 0; i < 10000; i++) begin
      id   = 1'($urandom_range(0, 1));
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      rbin = 1'($urandom_range(0, 1));
      e    = model(id, ra, rb, rbin);
      do_op(id, ra, rb, rbin, e.diff, e.bout, 1'b1);
    end
    wait_empty();
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/nibble_sub_sched.md
NIBBLE_SUB_SCHED -- requirements
Module: nibble_sub_sched

Interface
REQ-001 Parameter WIDTH, default 16: operand width in bits; SHALL be a multiple of 4.
REQ-002 clk  input  1  rising-edge clock, the only clock.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0 / req1  input  1 each  requester 0/1 operation request, level.
REQ-005 A0, B0 / A1, B1  input  WIDTH each  minuend and subtrahend for requester 0/1.
REQ-006 Bin0 / Bin1  input  1 each  borrow-in for requester 0/1.
REQ-007 gnt0 / gnt1  output  1 each  one-cycle grant pulse; operands captured.
REQ-008 busy  output  1  high while an operation is in flight.
REQ-009 done  output  1  one-cycle result-valid pulse.
REQ-010 done_id  output  1  requester owning the current result (0/1).
REQ-011 Diff  output  WIDTH  result A - B - Bin, modulo 2^WIDTH.
REQ-012 Borrow_out  output  1  final borrow of the result.

Function
REQ-013 Datapath SHALL be a single shared 4-bit subtract slice: diff = a^b^bin, bout = (~a&b) | ((~a|b)&bin), applied per bit.
REQ-014 FSM SHALL have states IDLE and RUN; nibble counter cnt spans 0..WIDTH/4-1.
REQ-015 IDLE, no req high: SHALL hold state; busy=0.
REQ-016 IDLE, at least one req high at a rising edge: SHALL capture the winner's A, B and Bin, pulse that gnt for the following cycle, set busy=1, clear cnt, and enter RUN.
REQ-017 Arbitration SHALL be round-robin. With a single req, that requester wins. With both high, the requester not granted last wins. After reset, requester 0 wins the first tie.
REQ-018 RUN, each edge: SHALL subtract captured nibble cnt with the running borrow (Bin for cnt=0), store the 4-bit result, update the running borrow, and increment cnt.
REQ-019 On the edge processing the last nibble, the block SHALL:
  - load Diff and Borrow_out;
  - drive done=1 and done_id=owner for exactly the next cycle;
  - clear busy and return to IDLE.
REQ-020 Latency: done SHALL rise WIDTH/4 edges after the capture edge (4 for WIDTH=16); sustained throughput is one operation per WIDTH/4+1 cycles.
REQ-021 Requests SHALL NOT be sampled in RUN; req and operand changes during RUN SHALL have no effect on the operation in flight.
REQ-022 Diff, Borrow_out and done_id SHALL hold their values until the next done.
REQ-023 A grant in the same edge that done is asserted is permitted; done and the new gnt may be high together.
REQ-024 A requester SHALL drop its req after its gnt if it wants no further operation; a req held high is re-granted per REQ-017.
REQ-025 Result SHALL equal (A - B - Bin) mod 2^WIDTH. Borrow_out=1 iff A < B + Bin (unsigned).

Reset
REQ-026 While rst_n=0, outputs SHALL be:
  - gnt0=gnt1=0, busy=0, done=0, done_id=0;
  - Diff=0, Borrow_out=0.
REQ-027 While rst_n=0, internal state SHALL be: FSM in IDLE, cnt=0, captured operands=0, round-robin pointer such that requester 0 wins the next tie.
REQ-028 Reset asserted during RUN SHALL abort the operation immediately; no done SHALL follow for it.

Verification
REQ-029 req0, A0=0xAAAA, B0=0x5555, Bin0=0 -> gnt0 pulse; done 4 edges after capture; Diff=0x5555, Borrow_out=0, done_id=0.
REQ-030 req1, A1=0x0000, B1=0x0001, Bin1=0 -> Diff=0xFFFF, Borrow_out=1, done_id=1.
REQ-031 req0, A0=B0=0x1234, Bin0=1 -> Diff=0xFFFF, Borrow_out=1. Cross-nibble borrow case A0=0x1000, B0=0x0001 -> Diff=0x0FFF, Borrow_out=0.
REQ-032 req0 and req1 both high from reset, held -> grants alternate 0,1,0,1. Each done carries the matching done_id and result. Operand changes during RUN are ignored.
REQ-033 rst_n pulsed low during RUN (cnt=2) -> all outputs return to reset values, no done. A new req after release completes normally.
REQ-034 Random 10k operations with random req, operands and Bin -> Diff and Borrow_out match the REQ-025 model. No done is lost and none is duplicated.
